// File: rtl/vga_fb_top.sv
// VGA timing generator with framebuffer address generation, pixel replication,
// test patterns and a latency-matched output pipeline.
module vga_fb_top #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int SCALE    = 1,
  parameter int RD_LAT   = 1,
  parameter int ADDR_W   = 18,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic              CLK,
  input  logic              RST_BTN,
  input  logic [1:0]        mode,
  input  logic [15:0]       vram_data,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              VGA_HS_O,
  output logic              VGA_VS_O,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Internal counters may be wider than the exported coordinates (525 lines > 9 bits).
  localparam int HC_W = ($clog2(H_TOTAL) > X_W) ? $clog2(H_TOTAL) : X_W;
  localparam int VC_W = ($clog2(V_TOTAL) > Y_W) ? $clog2(V_TOTAL) : Y_W;

  localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT      = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] H_ACT_LAST = HC_W'(H_ACTIVE - 1);
  localparam logic [HC_W-1:0] HS_BEG     = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END     = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HC_W-1:0] H_MASK     = HC_W'(SCALE - 1);
  localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT      = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VS_BEG     = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END     = VC_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VC_W-1:0] V_MASK     = VC_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE / SCALE);

  localparam logic [1:0] MODE_FB    = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_BLACK = 2'd2;

  logic [HC_W-1:0]   h;
  logic [VC_W-1:0]   v;
  logic              h_wrap, frame_end;
  logic              raw_act, raw_hs, raw_vs, raw_first;
  logic              group_end, line_rep_end;
  logic [ADDR_W-1:0] rd_addr, line_base, addr_hold;
  logic [1:0]        mode_q;
  logic [2:0]        bar;
  logic [RD_LAT-1:0] act_p, hs_p, vs_p, first_p;
  logic [2:0]        bar_p [RD_LAT];
  logic [7:0]        r_d, g_d, b_d;

  assign h_wrap    = (h == H_LAST);
  assign frame_end = h_wrap && (v == V_LAST);
  assign raw_act   = (h < H_ACT) && (v < V_ACT);
  assign raw_hs    = ((h >= HS_BEG) && (h < HS_END)) ? HS_POL : ~HS_POL;
  assign raw_vs    = ((v >= VS_BEG) && (v < VS_END)) ? VS_POL : ~VS_POL;
  assign raw_first = (h == '0) && (v == '0);
  // SCALE is a power of two, so the modulo reduces to a mask.
  assign group_end    = ((h & H_MASK) == H_MASK);
  assign line_rep_end = ((v & V_MASK) == V_MASK);

  assign x = h[X_W-1:0];
  assign y = v[Y_W-1:0];
  assign vram_addr = raw_act ? rd_addr : addr_hold;

  // Horizontal / vertical raster counters.
  always_ff @(posedge CLK) begin
    if (!RST_BTN) begin
      h <= '0;
      v <= '0;
    end else if (h_wrap) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Read address walk: step per pixel group, rewind to the line base at line end,
  // and advance the base only after the last repeat of a source line.
  always_ff @(posedge CLK) begin
    if (!RST_BTN) begin
      rd_addr   <= '0;
      line_base <= '0;
      addr_hold <= '0;
    end else begin
      if (raw_act) addr_hold <= rd_addr;
      if (frame_end) begin
        rd_addr   <= '0;
        line_base <= '0;
      end else if (raw_act && (h == H_ACT_LAST)) begin
        if (line_rep_end) begin
          line_base <= line_base + LINE_STEP;
          rd_addr   <= line_base + LINE_STEP;
        end else begin
          rd_addr <= line_base;
        end
      end else if (raw_act && group_end) begin
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  // Mode is latched once per frame so a pattern never changes mid-picture.
  always_ff @(posedge CLK) begin
    if (!RST_BTN) mode_q <= 2'd0;
    else if (raw_first) mode_q <= mode;
  end

  // Bar index = floor(h*8/H_ACTIVE), found by comparing against constant thresholds.
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h >= HC_W'((k * H_ACTIVE + 7) / 8)) bar = bar + 3'd1;
    end
  end

  // Control pipeline matching the VRAM read latency.
  always_ff @(posedge CLK) begin
    if (!RST_BTN) begin
      act_p   <= '0;
      first_p <= '0;
      hs_p    <= {RD_LAT{~HS_POL}};
      vs_p    <= {RD_LAT{~VS_POL}};
      for (int i = 0; i < RD_LAT; i++) bar_p[i] <= 3'd0;
    end else begin
      act_p[0]   <= raw_act;
      first_p[0] <= raw_first;
      hs_p[0]    <= raw_hs;
      vs_p[0]    <= raw_vs;
      bar_p[0]   <= bar;
      for (int i = 1; i < RD_LAT; i++) begin
        act_p[i]   <= act_p[i-1];
        first_p[i] <= first_p[i-1];
        hs_p[i]    <= hs_p[i-1];
        vs_p[i]    <= vs_p[i-1];
        bar_p[i]   <= bar_p[i-1];
      end
    end
  end

  // Colour selection for the pixel whose VRAM word is arriving now.
  always_comb begin
    r_d = 8'h00;
    g_d = 8'h00;
    b_d = 8'h00;
    if (act_p[RD_LAT-1]) begin
      case (mode_q)
        MODE_FB: begin
          r_d = {vram_data[15:11], vram_data[15:13]};
          g_d = {vram_data[10:5], vram_data[10:9]};
          b_d = {vram_data[4:0], vram_data[4:2]};
        end
        MODE_BARS: begin
          r_d = {8{bar_p[RD_LAT-1][2]}};
          g_d = {8{bar_p[RD_LAT-1][1]}};
          b_d = {8{bar_p[RD_LAT-1][0]}};
        end
        MODE_BLACK: begin
          r_d = 8'h00;
        end
        default: begin
          r_d = 8'hFF;
          g_d = 8'hFF;
          b_d = 8'hFF;
        end
      endcase
    end
  end

  // Final output register; colour, syncs and frame_start leave together.
  always_ff @(posedge CLK) begin
    if (!RST_BTN) begin
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
      VGA_HS_O    <= ~HS_POL;
      VGA_VS_O    <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      VGA_R       <= r_d;
      VGA_G       <= g_d;
      VGA_B       <= b_d;
      VGA_HS_O    <= hs_p[RD_LAT-1];
      VGA_VS_O    <= vs_p[RD_LAT-1];
      frame_start <= first_p[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_vga_fb_top.sv
// Bench for vga_fb_top: two reduced-timing instances (SCALE=1/RD_LAT=1 and
// SCALE=2/RD_LAT=3 with positive syncs) checked every cycle against a raster model.
module tb_vga_fb_top;

  localparam int HA = 64, HF = 4, HSY = 8, HB = 4;
  localparam int VA = 24, VF = 2, VSY = 2, VB = 2;
  localparam int HT = HA + HF + HSY + HB;  // 80
  localparam int VT = VA + VF + VSY + VB;  // 30
  localparam int FR = HT * VT;             // 2400
  localparam int S1 = 1, L1 = 1, S2 = 2, L2 = 3;

  logic        CLK = 1'b0;
  logic        RST_BTN = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] vd1 = 16'h0, vd2 = 16'h0;
  logic [17:0] a1, a2;
  logic        hs1, vs1, hs2, vs2, fs1, fs2;
  logic [7:0]  r1, g1, b1, r2, g2, b2;
  logic [9:0]  x1, x2;
  logic [8:0]  y1, y2;

  vga_fb_top #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .SCALE(S1), .RD_LAT(L1)
  ) u1 (
    .CLK(CLK), .RST_BTN(RST_BTN), .mode(mode), .vram_data(vd1), .vram_addr(a1),
    .VGA_HS_O(hs1), .VGA_VS_O(vs1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
    .x(x1), .y(y1), .frame_start(fs1)
  );

  vga_fb_top #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .SCALE(S2), .RD_LAT(L2)
  ) u2 (
    .CLK(CLK), .RST_BTN(RST_BTN), .mode(mode), .vram_data(vd2), .vram_addr(a2),
    .VGA_HS_O(hs2), .VGA_VS_O(vs2), .VGA_R(r2), .VGA_G(g2), .VGA_B(b2),
    .x(x2), .y(y2), .frame_start(fs2)
  );

  always #5 CLK = ~CLK;

  int   k = 0;        // cycles since reset release (0 in the first post-reset cycle)
  bit   rs = 1'b0;    // RST_BTN as seen by the last edge
  bit   started = 1'b0;
  int   epoch = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cur_mode = 0;
  int   fs_cnt1 = 0, fs_cnt2 = 0, last_fs1 = -1;
  logic [17:0] hist1 [8];
  logic [17:0] hist2 [8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s epoch=%0d k=%0d got %h want %h", nm, epoch, k, got, want);
    end
  endtask

  // Framebuffer contents: a few marker words, otherwise a scrambled address.
  function automatic logic [15:0] mem(input int a);
    case (a)
      5:       return 16'hF800;
      6:       return 16'h07E0;
      7:       return 16'h001F;
      1210:    return 16'h0000;
      default: return 16'(a * 40503 + 77);
    endcase
  endfunction

  // Word address of raster position (h,v); blanking repeats the last active pixel's address.
  function automatic int exp_addr(input int h, input int v, input int s);
    int hh = h, vv = v;
    if (vv >= VA) begin
      vv = VA - 1;
      hh = HA - 1;
    end else if (hh >= HA) begin
      hh = HA - 1;
    end
    return (vv / s) * (HA / s) + hh / s;
  endfunction

  function automatic logic [23:0] colour(input int m, input int hp, input logic [15:0] d);
    int bi;
    case (m)
      0: return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
      1: begin
        bi = hp * 8 / HA;
        return {{8{bi[2]}}, {8{bi[1]}}, {8{bi[0]}}};
      end
      2: return 24'h000000;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  function automatic logic [63:0] expect_out(input int kk, input int s, input int l, input bit pol);
    int hk = kk % HT, vk = (kk / HT) % VT, p = kk - l - 1, hp, vp;
    logic hs = ~pol, vs = ~pol, fs = 1'b0;
    logic [23:0] rgb = 24'h0;
    logic [17:0] ea = 18'(exp_addr(hk, vk, s));
    if (p >= 0) begin
      hp = p % HT;
      vp = (p / HT) % VT;
      if (hp >= HA + HF && hp < HA + HF + HSY) hs = pol;
      if (vp >= VA + VF && vp < VA + VF + VSY) vs = pol;
      fs = (hp == 0) && (vp == 0);
      if (hp < HA && vp < VA) rgb = colour(cur_mode, hp, mem(exp_addr(hp, vp, s)));
    end
    return {ea, hs, vs, rgb, 10'(hk), 9'(vk), fs};
  endfunction

  function automatic logic [63:0] reset_out(input bit pol);
    return {18'h0, ~pol, ~pol, 24'h0, 10'h0, 9'h0, 1'b0};
  endfunction

  always @(posedge CLK) begin
    rs <= RST_BTN;
    if (!RST_BTN) begin
      k       <= 0;
      started <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  // Memory model plus per-cycle compare and pinned literal checks.
  always @(negedge CLK) begin
    if (started) begin
      if (!rs) cur_mode = 0;
      if (RST_BTN && (k % FR == 0)) cur_mode = mode;
      hist1[k % 8] = a1;
      hist2[k % 8] = a2;
      vd1 = (k >= L1) ? mem(int'(hist1[(k - L1) % 8])) : 16'h0;
      vd2 = (k >= L2) ? mem(int'(hist2[(k - L2) % 8])) : 16'h0;

      chk("cycle_u1", {a1, hs1, vs1, r1, g1, b1, x1, y1, fs1},
          rs ? expect_out(k, S1, L1, 1'b0) : reset_out(1'b0));
      chk("cycle_u2", {a2, hs2, vs2, r2, g2, b2, x2, y2, fs2},
          rs ? expect_out(k, S2, L2, 1'b1) : reset_out(1'b1));

      if (!rs) last_fs1 = -1;
      if (rs && fs1) begin
        if (last_fs1 >= 0) chk("fs_period_u1", 64'(k - last_fs1), 64'(FR));
        last_fs1 = k;
      end
      if (rs && epoch == 1 && fs1) fs_cnt1++;
      if (rs && epoch == 1 && fs2) fs_cnt2++;

      if (!rs && RST_BTN && epoch == 2) begin
        chk("rst_xy", {54'h0, x1, y1}, 64'h0);
        chk("rst_addr", 64'(a1), 64'h0);
        chk("rst_rgb", 64'({r1, g1, b1}), 64'h0);
        chk("rst_sync_u1", 64'({hs1, vs1}), 64'h3);
        chk("rst_sync_u2", 64'({hs2, vs2}), 64'h0);
      end

      if (rs && epoch == 1) begin
        case (k)
          1:    chk("fs_pre", 64'(fs1), 64'h0);
          2:    begin chk("pix00_fs", 64'(fs1), 64'h1); chk("u2_addr_h2", 64'(a2), 64'h1); end
          3:    chk("fs_post", 64'(fs1), 64'h0);
          4:    chk("u2_addr_h4", 64'(a2), 64'h2);
          7:    chk("rgb_F800", 64'({r1, g1, b1}), 64'hFF0000);
          8:    chk("rgb_07E0", 64'({r1, g1, b1}), 64'h00FF00);
          9:    chk("rgb_001F", 64'({r1, g1, b1}), 64'h0000FF);
          14:   chk("u2_rgb_h10", 64'({r2, g2, b2}), 64'hFF0000);
          15:   chk("u2_rgb_h11", 64'({r2, g2, b2}), 64'hFF0000);
          69:   chk("hs_before", 64'(hs1), 64'h1);
          70:   begin chk("hs_first", 64'(hs1), 64'h0); chk("u1_addr_hold", 64'(a1), 64'd63); end
          71:   chk("u2_hs_before", 64'(hs2), 64'h0);
          72:   chk("u2_hs_first", 64'(hs2), 64'h1);
          77:   chk("hs_last", 64'(hs1), 64'h0);
          78:   chk("hs_after", 64'(hs1), 64'h1);
          80:   chk("u1_addr_line1", 64'(a1), 64'd64);
          81:   chk("u2_addr_line1", 64'(a2), 64'd0);
          160:  chk("u2_addr_line2", 64'(a2), 64'd32);
          1500: chk("fb_after_mode_change", 64'({r1, g1, b1}), 64'h0);
          1840: chk("u2_addr_line23", 64'(a2), 64'd352);
          1903: chk("u2_addr_last", 64'(a2), 64'd383);
          1904: chk("u2_addr_hold", 64'(a2), 64'd383);
          2081: chk("vs_before", 64'(vs1), 64'h1);
          2082: chk("vs_first", 64'(vs1), 64'h0);
          2241: chk("vs_last", 64'(vs1), 64'h0);
          2242: chk("vs_after", 64'(vs1), 64'h1);
          2401: chk("white_pre", 64'({r1, g1, b1}), 64'h0);
          2402: chk("white_pix0", 64'({r1, g1, b1}), 64'hFFFFFF);
          4802: chk("bar0", 64'({r1, g1, b1}), 64'h000000);
          4810: chk("bar1", 64'({r1, g1, b1}), 64'h0000FF);
          4812: chk("u2_bar1", 64'({r2, g2, b2}), 64'h0000FF);
          4826: chk("bar3", 64'({r1, g1, b1}), 64'h00FFFF);
          4865: chk("bar7", 64'({r1, g1, b1}), 64'hFFFFFF);
          4872: chk("bar_blank", 64'({r1, g1, b1}), 64'h000000);
          7210: chk("black_pix8", 64'({r1, g1, b1}), 64'h000000);
          default: ;
        endcase
      end

      if (rs && epoch == 2 && k == 7) chk("rgb_F800_after_rst", 64'({r1, g1, b1}), 64'hFF0000);
    end
  end

  initial begin
    RST_BTN = 1'b0;
    mode    = 2'd0;
    repeat (3) @(posedge CLK);
    #1 RST_BTN = 1'b1;
    epoch = 1;
    repeat (1000) @(posedge CLK);
    #1 mode = 2'd3;                 // k=1000, frame 0 stays framebuffer
    repeat (FR) @(posedge CLK);
    #1 mode = 2'd1;                 // k=3400, frame 2 becomes bars
    repeat (FR) @(posedge CLK);
    #1 mode = 2'd2;                 // k=5800, frame 3 becomes black
    repeat (3 * FR + 20 * HT + 30 - 5800) @(posedge CLK);
    #1 RST_BTN = 1'b0;              // k=8830: h=30, v=20 of frame 3
    mode = 2'd0;
    repeat (3) @(posedge CLK);
    #1;
    chk("fs_per_frame_u1", 64'(fs_cnt1), 64'd4);
    chk("fs_per_frame_u2", 64'(fs_cnt2), 64'd4);
    RST_BTN = 1'b1;
    epoch = 2;
    repeat (FR + 200) @(posedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
